// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - EX-stage ALU with valid/ready handshake and iterative one-bit-per-cycle shifter
// Single-cycle ops finish on the accept edge; SLL/SRL take shamt extra cycles.

package ALUType;
  typedef enum logic [3:0] {
    ALU_NONE      = 4'd0,
    ALU_ADD       = 4'd1,
    ALU_SUB       = 4'd2,
    ALU_AND       = 4'd3,
    ALU_OR        = 4'd4,
    ALU_LESS_THAN = 4'd5,
    ALU_SLL       = 4'd6,
    ALU_SRL       = 4'd7
  } alu_cmd_t;
endpackage

module alu_exec
  import ALUType::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  alu_cmd_t           alu_cmd,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               overflow,
  output logic               illegal
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_next;
  state_t             w_accept_state;
  logic               w_in_ready;
  logic               w_accept;
  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_alu_res;
  logic               w_alu_ovf;
  logic               w_alu_ill;
  logic               w_is_shift;
  logic [WIDTH-1:0]   w_shift_next;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_shreg;
  logic [SHAMT_W-1:0] r_cnt;
  logic               r_shl;
  logic               r_overflow;
  logic               r_illegal;

  // Result of the command currently presented on the inputs.
  always_comb begin
    w_sum      = op_a + op_b;
    w_diff     = op_a - op_b;
    w_alu_res  = '0;
    w_alu_ovf  = 1'b0;
    w_alu_ill  = 1'b0;
    w_is_shift = 1'b0;
    case (alu_cmd)
      ALU_ADD: begin
        w_alu_res = w_sum;
        w_alu_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (w_sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_SUB: begin
        w_alu_res = w_diff;
        w_alu_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (w_diff[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_AND:       w_alu_res = op_a & op_b;
      ALU_OR:        w_alu_res = op_a | op_b;
      ALU_LESS_THAN: w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLL, ALU_SRL: begin
        w_is_shift = 1'b1;
        w_alu_res  = op_b;
      end
      default:       w_alu_ill = 1'b1;
    endcase
  end

  assign w_accept_state = (w_is_shift && (shamt != '0)) ? S_SHIFT : S_DONE;
  assign w_shift_next   = r_shl ? {r_shreg[WIDTH-2:0], 1'b0} : {1'b0, r_shreg[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) w_state_next = w_accept_state;
      end
      S_SHIFT: begin
        if (r_cnt == SHAMT_W'(1)) w_state_next = S_DONE;
      end
      S_DONE: begin
        w_in_ready = out_ready;
        if (out_ready) w_state_next = in_valid ? w_accept_state : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_accept = in_valid && w_in_ready;

  // Shift commands also preload result with op_b so shamt==0 needs no SHIFT pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result   <= '0;
      r_shreg    <= '0;
      r_cnt      <= '0;
      r_shl      <= 1'b0;
      r_overflow <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (w_accept) begin
      r_result   <= w_alu_res;
      r_overflow <= w_alu_ovf;
      r_illegal  <= w_alu_ill;
      r_shreg    <= op_b;
      r_cnt      <= shamt;
      r_shl      <= (alu_cmd == ALU_SLL);
    end else if (r_state == S_SHIFT) begin
      r_shreg <= w_shift_next;
      r_cnt   <= r_cnt - SHAMT_W'(1);
      if (r_cnt == SHAMT_W'(1)) r_result <= w_shift_next;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign zero      = (r_result == '0);
  assign overflow  = r_overflow;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - scoreboard bench for alu_exec
// Expected results come from a behavioural model pushed at accept time.

module tb_alu_exec;
  import ALUType::*;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        ov;
    logic        il;
    logic [7:0]  lat;
  } exp_t;

  typedef struct packed {
    alu_cmd_t    c;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  s;
  } op_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  alu_cmd_t    alu_cmd = ALU_NONE;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [4:0]  shamt = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        illegal;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;

  alu_exec #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_cmd(alu_cmd), .op_a(op_a), .op_b(op_b), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .overflow(overflow), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(alu_cmd_t c, logic [31:0] a, logic [31:0] b, logic [4:0] s);
    logic signed [32:0] t;
    exp_t e;
    e = '0;
    e.lat = 8'd1;
    case (c)
      ALU_ADD: begin t = $signed({a[31], a}) + $signed({b[31], b}); e.res = t[31:0]; e.ov = t[32] ^ t[31]; end
      ALU_SUB: begin t = $signed({a[31], a}) - $signed({b[31], b}); e.res = t[31:0]; e.ov = t[32] ^ t[31]; end
      ALU_AND:       e.res = a & b;
      ALU_OR:        e.res = a | b;
      ALU_LESS_THAN: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLL: begin e.res = b << s; e.lat = 8'd1 + 8'(s); end
      ALU_SRL: begin e.res = b >> s; e.lat = 8'd1 + 8'(s); end
      default:       e.il = 1'b1;
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  // Present a command, wait for the accept edge, then scramble the inputs.
  task automatic send(input alu_cmd_t c, input logic [31:0] a, input logic [31:0] b, input logic [4:0] s);
    int n;
    n = 0;
    alu_cmd = c; op_a = a; op_b = b; shamt = s; in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    alu_cmd = ALU_NONE; op_a = $urandom; op_b = $urandom; shamt = 5'($urandom);
    sb.push_back(model(c, a, b, s));
  endtask

  task automatic collect(output logic [31:0] r, output logic z, output logic ov, output logic il,
                         output int lat, output bit to, output bit busy);
    lat = 1; to = 1'b0; busy = 1'b0;
    while (out_valid !== 1'b1) begin
      if (in_ready !== 1'b0) busy = 1'b1;
      if (lat >= 100) begin to = 1'b1; break; end
      @(posedge clk); #1; lat++;
    end
    r = result; z = zero; ov = overflow; il = illegal;
    if (in_ready !== 1'b0) busy = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    #1;
    n_checks++;
    if ({in_ready, out_valid, result, zero, overflow, illegal} !== {1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0})
      $display("FAIL reset_initial got rdy=%b vld=%b res=%h z=%b ov=%b il=%b want 1 0 0 1 0 0",
               in_ready, out_valid, result, zero, overflow, illegal);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0);
    e = sb.pop_back();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid, result, zero, overflow, illegal} !== {1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0})
      $display("FAIL reset_async got rdy=%b vld=%b res=%h z=%b ov=%b il=%b want 1 0 0 1 0 0 (aborted %h)",
               in_ready, out_valid, result, zero, overflow, illegal, e.res);
    else n_pass++;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({in_ready, out_valid, result} !== {1'b1, 1'b0, 32'd0})
      $display("FAIL reset_release got rdy=%b vld=%b res=%h want 1 0 0", in_ready, out_valid, result);
    else n_pass++;
  endtask

  task automatic test_arith();
    op_t tbl[4];
    logic [31:0] r; logic z, ov, il; int lat; bit to, busy; exp_t e;
    tbl[0] = '{ALU_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0};
    tbl[1] = '{ALU_ADD, 32'hFFFF_FFFF, 32'd1, 5'd0};
    tbl[2] = '{ALU_SUB, 32'h8000_0000, 32'd1, 5'd0};
    tbl[3] = '{ALU_SUB, 32'd5, 32'd7, 5'd0};
    foreach (tbl[i]) begin
      send(tbl[i].c, tbl[i].a, tbl[i].b, tbl[i].s);
      collect(r, z, ov, il, lat, to, busy);
      e = sb.pop_front();
      n_checks++;
      if ({r, z, ov, il} !== {e.res, e.z, e.ov, e.il})
        $display("FAIL arith[%0d] got res=%h z=%b ov=%b il=%b want res=%h z=%b ov=%b il=%b",
                 i, r, z, ov, il, e.res, e.z, e.ov, e.il);
      else n_pass++;
      n_checks++;
      if (to || lat != int'(e.lat)) $display("FAIL arith_lat[%0d] got %0d want %0d", i, lat, e.lat);
      else n_pass++;
    end
  endtask

  task automatic test_logic();
    op_t tbl[5];
    logic [31:0] r; logic z, ov, il; int lat; bit to, busy; exp_t e;
    tbl[0] = '{ALU_LESS_THAN, 32'hFFFF_FFFF, 32'd1, 5'd0};
    tbl[1] = '{ALU_LESS_THAN, 32'd5, 32'd5, 5'd0};
    tbl[2] = '{ALU_LESS_THAN, 32'd1, 32'hFFFF_FFFF, 5'd0};
    tbl[3] = '{ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, 5'd0};
    tbl[4] = '{ALU_OR, 32'h0000_F0F0, 32'h0000_0F0F, 5'd0};
    foreach (tbl[i]) begin
      send(tbl[i].c, tbl[i].a, tbl[i].b, tbl[i].s);
      collect(r, z, ov, il, lat, to, busy);
      e = sb.pop_front();
      n_checks++;
      if ({r, z, ov, il} !== {e.res, e.z, e.ov, e.il})
        $display("FAIL logic[%0d] got res=%h z=%b ov=%b il=%b want res=%h z=%b ov=%b il=%b",
                 i, r, z, ov, il, e.res, e.z, e.ov, e.il);
      else n_pass++;
      n_checks++;
      if (to || lat != int'(e.lat)) $display("FAIL logic_lat[%0d] got %0d want %0d", i, lat, e.lat);
      else n_pass++;
    end
  endtask

  task automatic test_shift();
    op_t tbl[4];
    logic [31:0] r; logic z, ov, il; int lat; bit to, busy; exp_t e;
    tbl[0] = '{ALU_SLL, 32'd0, 32'd1, 5'd31};
    tbl[1] = '{ALU_SRL, 32'd0, 32'h8000_0000, 5'd4};
    tbl[2] = '{ALU_SLL, 32'd0, 32'h1234_5678, 5'd0};
    tbl[3] = '{ALU_SRL, 32'd0, 32'hDEAD_BEEF, 5'd7};
    foreach (tbl[i]) begin
      send(tbl[i].c, tbl[i].a, tbl[i].b, tbl[i].s);
      collect(r, z, ov, il, lat, to, busy);
      e = sb.pop_front();
      n_checks++;
      if ({r, z, ov, il} !== {e.res, e.z, e.ov, e.il})
        $display("FAIL shift[%0d] got res=%h z=%b ov=%b il=%b want res=%h z=%b ov=%b il=%b",
                 i, r, z, ov, il, e.res, e.z, e.ov, e.il);
      else n_pass++;
      n_checks++;
      if (to || lat != int'(e.lat)) $display("FAIL shift_lat[%0d] got %0d want %0d", i, lat, e.lat);
      else n_pass++;
      n_checks++;
      if (busy) $display("FAIL shift_in_ready[%0d] got in_ready=1 while busy want 0", i);
      else n_pass++;
    end
  endtask

  task automatic test_none();
    op_t tbl[3];
    logic [31:0] r; logic z, ov, il; int lat; bit to, busy; exp_t e;
    tbl[0] = '{ALU_NONE, 32'd5, 32'd9, 5'd0};
    tbl[1] = '{ALU_ADD, 32'd2, 32'd3, 5'd0};
    tbl[2] = '{alu_cmd_t'(4'hF), 32'd5, 32'd9, 5'd3};
    foreach (tbl[i]) begin
      send(tbl[i].c, tbl[i].a, tbl[i].b, tbl[i].s);
      collect(r, z, ov, il, lat, to, busy);
      e = sb.pop_front();
      n_checks++;
      if ({r, z, ov, il} !== {e.res, e.z, e.ov, e.il})
        $display("FAIL none[%0d] got res=%h z=%b ov=%b il=%b want res=%h z=%b ov=%b il=%b",
                 i, r, z, ov, il, e.res, e.z, e.ov, e.il);
      else n_pass++;
      n_checks++;
      if (to || lat != int'(e.lat)) $display("FAIL none_lat[%0d] got %0d want %0d", i, lat, e.lat);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] r0;
    exp_t e;
    send(ALU_ADD, 32'd10, 32'd20, 5'd0);
    r0 = result;
    alu_cmd = ALU_ADD; op_a = 32'd1; op_b = 32'd1; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, in_ready, result} !== {1'b1, 1'b0, r0})
        $display("FAIL backpressure[%0d] got vld=%b rdy=%b res=%h want 1 0 %h", k, out_valid, in_ready, result, r0);
      else n_pass++;
    end
    in_valid = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if (r0 !== e.res) $display("FAIL backpressure_res got %h want %h", r0, e.res);
    else n_pass++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      alu_cmd = ALU_AND; op_a = $urandom; op_b = $urandom; shamt = '0; in_valid = 1'b1;
      sb.push_back(model(alu_cmd, op_a, op_b, shamt));
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if ({out_valid, result} !== {1'b1, e.res})
        $display("FAIL b2b[%0d] got vld=%b res=%h want 1 %h", k, out_valid, result, e.res);
      else n_pass++;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL b2b_drain got vld=%b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] r; logic z, ov, il; int lat; bit to, busy, seen; exp_t e;
    send(ALU_SLL, 32'd0, 32'd1, 5'd20);
    e = sb.pop_back();
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin @(posedge clk); #1; if (out_valid !== 1'b0) seen = 1'b1; end
    n_checks++;
    if (seen) $display("FAIL reset_mid_op got out_valid=1 for aborted shift (would be %h) want 0", e.res);
    else n_pass++;
    send(ALU_ADD, 32'd3, 32'd4, 5'd0);
    collect(r, z, ov, il, lat, to, busy);
    e = sb.pop_front();
    n_checks++;
    if (to || {r, z, ov, il} !== {e.res, e.z, e.ov, e.il})
      $display("FAIL after_reset got res=%h z=%b ov=%b il=%b want res=%h z=%b ov=%b il=%b",
               r, z, ov, il, e.res, e.z, e.ov, e.il);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic();
    test_shift();
    test_none();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/alu_exec.md
# alu_exec

Execution-side consumer of the ALU command bus: accepts an `ALUType::alu_cmd_t` command with two operands and a shift amount, and returns a registered result. It sits in the EX stage directly downstream of the ALU controller's `alu_cmd_out`. A valid/ready handshake on both sides lets the stage stall. ADD, SUB, AND, OR and LESS_THAN complete in one cycle; SLL and SRL run on an iterative one-bit-per-cycle shifter.

## Interface

- `WIDTH`, default 32, operand/result width.
- `SHAMT_W`, default 5, shift-amount width; must equal clog2(`WIDTH`).

Ports:

- `clk` (in, 1): clock, rising edge.
- `rst_n` (in, 1): reset, asynchronous, active-low.
- `in_valid` (in, 1): command valid.
- `in_ready` (out, 1): block can accept a command.
- `alu_cmd` (in, `ALUType::alu_cmd_t`): operation.
- `op_a` (in, `WIDTH`): operand A (rs).
- `op_b` (in, `WIDTH`): operand B (rt or immediate); the shifted value for SLL/SRL.
- `shamt` (in, `SHAMT_W`): shift amount, used only by SLL/SRL.
- `out_valid` (out, 1): result valid.
- `out_ready` (in, 1): consumer takes result.
- `result` (out, `WIDTH`): registered result.
- `zero` (out, 1): `result == 0`.
- `overflow` (out, 1): signed overflow on ADD/SUB; 0 for all other ops.
- `illegal` (out, 1): the command was NONE or an unknown encoding.

## Operation

- The FSM has three states: IDLE, SHIFT, DONE.
- Handshake and capture:
  - `in_ready` is 1 in IDLE, and in DONE when `out_ready` is 1 (same-cycle drain and refill). It is 0 otherwise.
  - A command is accepted when `in_valid && in_ready`.
  - `alu_cmd`, `op_a`, `op_b` and `shamt` are captured on acceptance. Input changes after that are ignored.
- IDLE, on accept:
  - ADD: `result = op_a + op_b` mod 2^WIDTH. `overflow` = both operands share a sign and the sum's sign differs. Go to DONE.
  - SUB: `result = op_a - op_b` mod 2^WIDTH. `overflow` = the operand signs differ and the result's sign differs from `op_a`'s. Go to DONE.
  - AND and OR: bitwise. Go to DONE.
  - LESS_THAN: signed compare. `result = {WIDTH-1 zeros, $signed(op_a) < $signed(op_b)}`. Go to DONE.
  - SLL and SRL:
    - Load the shift register with `op_b` and the down-counter with `shamt`.
    - If `shamt == 0`, go to DONE with `result = op_b`; otherwise go to SHIFT.
  - NONE or any other encoding: `result = 0`, `illegal = 1`. Go to DONE.
- SHIFT, each cycle:
  - Shift one bit: left for SLL, logical right for SRL, always zero-fill.
  - Decrement the counter.
  - When the counter goes 1→0, write the final value to `result` and go to DONE.
  - `in_ready` is 0 throughout.
- DONE:
  - `out_valid` is 1.
  - `result`, `zero`, `overflow` and `illegal` are held stable until `out_ready` is 1.
  - If `out_ready` is 1 and a new command is accepted in the same cycle, process it as in IDLE.
  - If `out_ready` is 1 and no new command arrives, go to IDLE.
- Flag rules:
  - `zero` is recomputed from the final result.
  - `overflow` and `illegal` are cleared for every newly accepted command unless that command sets them.

## Timing

- Reset (`rst_n` low, asynchronous):
  - State becomes IDLE.
  - `in_ready` = 1, `out_valid` = 0, `result` = 0.
  - `zero` = 1 (it is derived from `result`), `overflow` = 0, `illegal` = 0.
  - Counter and shift register clear.
- Reset asserted mid-SHIFT or in DONE aborts the operation. No result is ever presented for it.
- Latency, counted from the accept edge to `out_valid` high:
  - Single-cycle ops and NONE: 1 cycle.
  - SLL/SRL: `1 + shamt` cycles. `shamt = 31` gives 32 cycles; `shamt = 0` gives 1 cycle.
- Throughput: one single-cycle op per cycle when `out_ready` is held high (DONE→DONE chaining).
- Back-pressure: while `out_valid && !out_ready`, no outputs change and `in_ready` is 0.
- Boundaries: `result` is never X after reset. A shift counter that reaches 0 never underflows and never re-enters SHIFT.

## Test plan

- Reset and idle: pulse `rst_n` low mid-cycle → outputs go to reset values asynchronously: `in_ready` = 1, `out_valid` = 0, `result` = 0, `zero` = 1.
- Arithmetic wrap and overflow:
  - ADD 0x7FFFFFFF + 1 → `result` = 0x80000000, `overflow` = 1, one cycle later.
  - ADD 0xFFFFFFFF + 1 → `result` = 0, `zero` = 1, `overflow` = 0.
  - SUB 0x80000000 − 1 → `result` = 0x7FFFFFFF, `overflow` = 1.
- Compare and logic:
  - LESS_THAN −1 vs 1 → `result` = 1.
  - LESS_THAN 5 vs 5 → `result` = 0, `zero` = 1.
  - AND 0xF0F0 & 0xFF00 → 0xF000.
  - OR 0xF0F0 | 0x0F0F → 0xFFFF.
- Iterative shifts:
  - SLL `op_b` = 1, `shamt` = 31 → 0x80000000 after 32 cycles, with `in_ready` = 0 throughout.
  - SRL 0x80000000 by 4 → 0x08000000 after 5 cycles.
  - SLL by 0 → `op_b` after 1 cycle.
- Back-pressure and chaining:
  - Hold `out_ready` = 0 for 3 cycles after an ADD → `result` stable, `in_ready` = 0.
  - Then stream 4 ANDs with `out_ready` = 1 → 4 results on 4 consecutive cycles.
- NONE and reset mid-op:
  - NONE with `op_a` = 5 → `result` = 0, `illegal` = 1. The next ADD clears `illegal`.
  - Assert reset during SLL by 20 → no `out_valid` appears for it. The next command executes normally.
